seq_detector_mealy_param: RTL and testbench

Parametrised serial Mealy pattern detector. It samples one bit per enabled clock and compares the most recent `len` bits against a run-time programmable pattern of up to `MAX_LEN` bits. It supports overlapping and non-overlapping detection, and keeps a saturating match count. It sits between the input-switch sampling logic and the display/status outputs of the project top, replacing fixed-pattern detectors.

---
 rtl/seqdet_pkg.sv | 20 ++
 rtl/seqdet_sat_counter.sv | 40 ++++
 rtl/seq_detector_mealy_param.sv | 140 ++++++++++++++
 tb/tb_seq_detector_mealy_param.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
package seqdet_pkg;

  // Detection mode selected by the overlap input.
  typedef enum logic {
    NON_OVERLAP = 1'b0,
    OVERLAP     = 1'b1
  } mode_e;

  // Default geometry and pattern loaded at reset.
  localparam int unsigned DEF_MAX_LEN = 8;
  localparam logic [7:0]  DEF_PATTERN = 8'b0000_0111;
  localparam int unsigned DEF_LENGTH  = 3;

  // Width of a length field able to hold the values 0..max_len.
  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seqdet_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,   // active-high asynchronous reset
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear first, then increment unless already at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with asynchronous reset to zero.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detector_mealy_param.sv
// Serial Mealy detector comparing the newest len bits against a programmable
// pattern, with overlapping/non-overlapping modes and a saturating match count.
module seq_detector_mealy_param
  import seqdet_pkg::*;
#(
  parameter int unsigned         MAX_LEN = DEF_MAX_LEN,
  parameter int unsigned         CNT_W   = 8,
  parameter logic [MAX_LEN-1:0]  DEF_PAT = MAX_LEN'(DEF_PATTERN),
  parameter int unsigned         DEF_LEN = DEF_LENGTH,
  localparam int unsigned        LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,     // active-high asynchronous reset
  input  logic               en,
  input  logic               din,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               overlap,
  input  logic               clr_cnt,
  output logic               match,
  output logic               match_q,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);
  localparam logic [LEN_W-1:0] LEN_RST  = LEN_W'(DEF_LEN);

  // Bit mask selecting the low `len` positions of a window.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // Requested lengths beyond MAX_LEN fall back to the full window.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len > LEN_MAX) begin
      return LEN_MAX;
    end else begin
      return len;
    end
  endfunction

  // Pattern, length, history and valid-history count.
  logic [MAX_LEN-1:0] pat_q,  pat_d;
  logic [LEN_W-1:0]   len_q,  len_d;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_d;

  // Compare path.
  logic [MAX_LEN-1:0] window_s;
  logic [MAX_LEN-1:0] mask_s;
  logic               hist_ok_s;
  logic               cmp_ok_s;
  logic               match_s;
  mode_e              mode_s;

  // The newest bit sits at position 0, previous samples above it.
  assign window_s = {hist_q, din};
  assign mask_s   = len_mask(len_q);
  assign mode_s   = mode_e'(overlap);

  // Mealy compare: enough valid history plus a masked pattern equality.
  // Reset gates the flag so it is low while reset is held.
  always_comb begin
    hist_ok_s = ((LEN_W + 1)'(fill_q) + (LEN_W + 1)'(1)) >= (LEN_W + 1)'(len_q);
    cmp_ok_s  = ((window_s & mask_s) == (pat_q & mask_s));
    if (rst_n || !en || load || (len_q == '0)) begin
      match_s = 1'b0;
    end else begin
      match_s = hist_ok_s & cmp_ok_s;
    end
  end

  assign match   = match_s;
  assign match_d = match_s;

  // Next-state: load has priority over a sample; a non-overlapping match
  // invalidates the history so the next detection starts from scratch.
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (load) begin
      pat_d  = pat_in;
      len_d  = clamp_len(len_in);
      fill_d = '0;
    end else if (en) begin
      hist_d = window_s[MAX_LEN-2:0];
      if (match_s && (mode_s == NON_OVERLAP)) begin
        fill_d = '0;
      end else if (fill_q < FILL_MAX) begin
        fill_d = fill_q + LEN_W'(1);
      end else begin
        fill_d = fill_q;
      end
    end else begin
      fill_d = fill_q;
    end
  end

  // Detector state and registered match flag.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pat_q   <= DEF_PAT;
      len_q   <= LEN_RST;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  seqdet_sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (match_s),
    .clr   (clr_cnt),
    .q     (match_cnt)
  );

endmodule

// File: tb/tb_seq_detector_mealy_param.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor checks them.
module tb_seq_detector_mealy_param;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       din;
  logic       load;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic       overlap;
  logic       clr_cnt;
  logic       match,  match2;
  logic       match_q, match_q2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic m;
    int   c8;
    int   c2;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: only the bits that still count toward a match.
  logic       m_hist[$];
  logic [7:0] m_pat;
  int         m_len;
  int         m_c8;
  int         m_c2;

  logic [7:0] cur_pat;
  logic [3:0] cur_len;
  logic       cur_ov;

  seq_detector_mealy_param dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .load(load),
    .pat_in(pat_in), .len_in(len_in), .overlap(overlap), .clr_cnt(clr_cnt),
    .match(match), .match_q(match_q), .match_cnt(match_cnt)
  );

  seq_detector_mealy_param #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .load(load),
    .pat_in(pat_in), .len_in(len_in), .overlap(overlap), .clr_cnt(clr_cnt),
    .match(match2), .match_q(match_q2), .match_cnt(match_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_match(input logic e, input logic d, input logic l);
    logic b;
    if (!e || l || m_len == 0) return 1'b0;
    if (m_hist.size() < m_len - 1) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      b = (i == 0) ? d : m_hist[m_hist.size() - i];
      if (b != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_pat = 8'h07;
    m_len = 3;
    m_c8 = 0;
    m_c2 = 0;
    cur_pat = 8'h07;
    cur_len = 4'd3;
  endtask

  // One clock of stimulus; the expectation is queued for the monitor.
  task automatic step(input logic e, input logic d, input logic l, input logic cl);
    exp_t x;
    @(negedge clk);
    en = e; din = d; load = l; pat_in = cur_pat; len_in = cur_len;
    overlap = cur_ov; clr_cnt = cl;
    x.m = model_match(e, d, l);
    if (cl) begin
      m_c8 = 0;
      m_c2 = 0;
    end else if (x.m) begin
      if (m_c8 < 255) m_c8++;
      if (m_c2 < 3) m_c2++;
    end
    x.c8 = m_c8;
    x.c2 = m_c2;
    if (l) begin
      m_pat = cur_pat;
      m_len = (cur_len > 4'd8) ? 8 : int'(cur_len);
      m_hist.delete();
    end else if (e) begin
      if (x.m && !cur_ov) begin
        m_hist.delete();
      end else begin
        m_hist.push_back(d);
        if (m_hist.size() > 7) void'(m_hist.pop_front());
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic do_load(input logic [7:0] p, input logic [3:0] li);
    cur_pat = p;
    cur_len = li;
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Reset pulse that begins and ends between two rising edges.
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    en = 1'b1; din = 1'b1; load = 1'b0; clr_cnt = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("arst_match", int'(match), 0);
    chk("arst_match_q", int'(match_q), 0);
    chk("arst_cnt", int'(match_cnt), 0);
    chk("arst_cnt2", int'(match_cnt2), 0);
    #1;
    rst_n = 1'b0;
    en = 1'b0;
    model_reset();
  endtask

  // Monitor: Mealy flag just before the edge, registered outputs just after.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("match", int'(match), int'(x.m));
        chk("match_w2", int'(match2), int'(x.m));
        @(posedge clk);
        #1;
        chk("match_q", int'(match_q), int'(x.m));
        chk("match_cnt", int'(match_cnt), x.c8);
        chk("match_cnt_w2", int'(match_cnt2), x.c2);
      end
    end
  end

  initial begin
    logic [7:0] p;
    int r;
    rst_n = 1'b1; en = 1'b0; din = 1'b0; load = 1'b0; pat_in = 8'h00;
    len_in = 4'd0; overlap = 1'b1; clr_cnt = 1'b0; cur_ov = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_match", int'(match), 0);
    chk("rst_match_q", int'(match_q), 0);
    chk("rst_cnt", int'(match_cnt), 0);
    @(negedge clk);
    rst_n = 1'b0;

    // Default pattern 111, overlapping: seven ones give five matches.
    cur_ov = 1'b1;
    repeat (7) step(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("ovl_cnt", int'(match_cnt), 5);
    chk("ovl_cnt_sat2", int'(match_cnt2), 3);

    // Same input non-overlapping after a mid-cycle reset: two matches.
    pulse_reset();
    cur_ov = 1'b0;
    repeat (7) step(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("novl_cnt", int'(match_cnt), 2);

    // Pattern 101 on 1,0,1,0,1: two matches overlapping, one otherwise.
    do_load(8'b101, 4'd3);
    cur_ov = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("p101_ovl_cnt", int'(match_cnt), 4);
    do_load(8'b101, 4'd3);
    cur_ov = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("p101_novl_cnt", int'(match_cnt), 5);

    // Enable gaps inside the sequence do not break it.
    do_load(8'b101, 4'd3);
    cur_ov = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("gap_cnt", int'(match_cnt), 7);

    // Load on the final bit discards it; history restarts from empty.
    step(1'b1, 1'b1, 1'b0, 1'b0); step(1'b1, 1'b0, 1'b0, 1'b0);
    cur_pat = 8'b101; cur_len = 4'd3;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("load_prio_cnt", int'(match_cnt), 7);
    // Clear coincident with a match leaves zero.
    step(1'b1, 1'b0, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #2;
    chk("clr_vs_match", int'(match_cnt), 0);

    // Zero length never matches.
    do_load(8'h00, 4'd0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    // Oversized length clamps to the full eight-bit window.
    do_load(8'hA5, 4'd15);
    p = 8'hA5;
    for (int i = 7; i >= 0; i--) step(1'b1, p[i], 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("len_clamp_cnt", int'(match_cnt), 1);
    // Single-bit pattern follows din whenever enabled.
    do_load(8'h01, 4'd1);
    for (int i = 0; i < 24; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

    // Randomised traffic with short patterns, mode toggles and clears.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 5) begin
        cur_pat = 8'($urandom);
        cur_len = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                               : 4'($urandom_range(1, 4));
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      end else if (r == 5) begin
        pulse_reset();
      end else begin
        if (r < 12) cur_ov = ~cur_ov;
        step(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 1'b0,
             ($urandom_range(0, 79) == 0));
      end
    end

    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
